fetch_ctrl: RTL
===============

# fetch_ctrl

Instruction-fetch sequencer for the 16-bit processor. It owns the program counter update policy: it issues instruction-memory requests at the current PC, advances the PC by 2 per accepted instruction, applies branch/jump redirects, and freezes on HALT. It also presents fetched instructions to the IF/ID boundary with a valid/stall handshake, and absorbs one in-flight response in a skid entry when decode stalls.

## Interface
- `WIDTH`, 16: PC, address and instruction width.
- `RESET_PC`, 16'h0000: PC value loaded on reset.
- `HALT_OPCODE`, 4'hF: value of instr[15:12] that identifies HALT.
- `clk`  in  1: single clock; all state updates on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `imem_req`  out  1: request to instruction memory; once high, held high until `imem_ready`.
- `imem_addr`  out  WIDTH: fetch address; stable while `imem_req` high.
- `imem_ready`  in  1: response valid; completes the request in the same cycle (zero-wait memory allowed).
- `imem_data`  in  WIDTH: instruction word, valid when `imem_ready`.
- `stall`  in  1: decode cannot accept; the output slot holds.
- `redirect`  in  1: taken branch/jump resolved downstream.
- `redirect_pc`  in  WIDTH: target; bit 0 forced to 0.
- `pc`  out  WIDTH: address of the next instruction to fetch.
- `if_instr`  out  WIDTH: fetched instruction (output slot).
- `if_pc_plus2`  out  WIDTH: address of `if_instr` + 2, for link/branch use.
- `if_valid`  out  1: slot holds a valid instruction; consumed on any cycle with `stall`=0.
- `halted`  out  1: high while in HALT.

## Operation
- States: BOOT, FETCH, WAIT, DRAIN, HALT.
- Reset: state=BOOT, pc=RESET_PC, if_valid=0, if_instr=0, if_pc_plus2=0, skid empty, imem_req=0, halted=0. Reset during WAIT/DRAIN abandons the request; memory shares `rst`.
- BOOT: no request; next state FETCH.
- FETCH: `imem_req`=1, `imem_addr`=pc, only when slot free-or-consumed (`!if_valid || !stall`), skid empty, and `redirect`=0. With `imem_ready` in the same cycle, the response is accepted. Otherwise go to WAIT.
- WAIT: `imem_req` held, address held. Stay until `imem_ready`; accept the response, then return to FETCH.
- Accept: if the slot is free or consumed this cycle, data goes to the slot (if_valid=1). Otherwise (`if_valid && stall`) it goes to the skid entry. pc <= pc+2 (mod 2^WIDTH), unless instr[15:12]==HALT_OPCODE, in which case pc is unchanged and next state is HALT. HALT instruction itself is still delivered.
- Skid: when `stall`=0 and skid full, skid moves to slot that edge, skid empties. No new request starts while skid full.
- Redirect (highest priority, overrides stall): pc <= redirect_pc & ~1, if_valid <= 0, skid cleared.
  - From FETCH/HALT: next state FETCH; halted drops next cycle.
  - From WAIT without `imem_ready`: go to DRAIN. With `imem_ready`: data discarded, go to FETCH.
- DRAIN: `imem_req` held at old address until `imem_ready`; data discarded; then FETCH. A further redirect in DRAIN updates pc, stays DRAIN.
- HALT: no requests; slot/skid still drain normally; leave only by redirect or rst.

## Timing
- First `imem_req` is in the 2nd cycle after `rst` deasserts (BOOT cycle first).
- Zero-wait memory, no stall: one instruction per cycle. Request at cycle n ⇒ if_valid with that word at n+1.
- N wait cycles add N cycles per instruction; `imem_addr` must not change while `imem_req`=1.
- Redirect at cycle n ⇒ request to the target no earlier than n+1 (FETCH), or the cycle after the stale response completes (DRAIN).
- pc 16'hFFFE advances to 16'h0000.

## Test plan
- Reset, zero-wait memory, instructions 0x1000.. ⇒ imem_addr 0x0000, 0x0002, 0x0004 on consecutive cycles starting 2nd cycle after reset. if_valid from 3rd; if_pc_plus2 0x0002, 0x0004.
- imem_ready delayed 2 cycles on addr 0x0004 ⇒ imem_req and imem_addr=0x0004 stable for 3 cycles; pc becomes 0x0006 only on accept.
- stall held 3 cycles with one response in flight ⇒ slot holds, word lands in skid, no new request. stall low ⇒ two instructions delivered in order on consecutive cycles.
- redirect to 0x0041 during WAIT ⇒ DRAIN; stale word never shows if_valid; next request at 0x0040.
- 0xF000 fetched at 0x0006 ⇒ delivered with if_valid, halted=1, pc stays 0x0006, no requests for 10 cycles. Then redirect to 0x0020 ⇒ halted=0, fetch at 0x0020.
- redirect to 0xFFFE, zero-wait ⇒ next addresses 0xFFFE, 0x0000.

Source files
------------

// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if
// Instruction-memory request/response bus between the fetch sequencer and
// the instruction memory.
//   imem_req   : request strobe, held high by the master until imem_ready
//   imem_addr  : fetch address, stable while imem_req is high
//   imem_ready : response strobe, completes the request in the same cycle
//   imem_data  : instruction word, valid while imem_ready is high
// Modports: master = fetch sequencer side, slave = memory side.

interface fetch_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             imem_req;
    logic [WIDTH-1:0] imem_addr;
    logic             imem_ready;
    logic [WIDTH-1:0] imem_data;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_data
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_data
    );
endinterface

// File: rtl/fetch_ctrl.sv
// fetch_ctrl
// Instruction-fetch sequencer for the 16-bit processor. Issues instruction
// memory requests at the PC, advances the PC by 2 per accepted instruction,
// applies branch/jump redirects, freezes on HALT, and presents fetched
// instructions to the IF/ID boundary through a one-entry output slot backed
// by a one-entry skid.
// Ports:
//   clk, rst         : clock, synchronous active-high reset
//   imem             : instruction-memory bus (master side)
//   i_stall          : decode cannot accept; output slot holds
//   i_redirect       : taken branch/jump resolved downstream
//   i_redirect_pc    : redirect target (bit 0 forced to 0)
//   o_pc             : address of the next instruction to fetch
//   o_if_instr       : fetched instruction in the output slot
//   o_if_pc_plus2    : address of o_if_instr plus 2
//   o_if_valid       : output slot holds a valid instruction
//   o_halted         : high while in HALT

module fetch_ctrl #(
    parameter int               WIDTH       = 16,
    parameter logic [WIDTH-1:0] RESET_PC    = '0,
    parameter logic [3:0]       HALT_OPCODE = 4'hF
) (
    input  logic             clk,
    input  logic             rst,
    fetch_ctrl_if.master     imem,
    input  logic             i_stall,
    input  logic             i_redirect,
    input  logic [WIDTH-1:0] i_redirect_pc,
    output logic [WIDTH-1:0] o_pc,
    output logic [WIDTH-1:0] o_if_instr,
    output logic [WIDTH-1:0] o_if_pc_plus2,
    output logic             o_if_valid,
    output logic             o_halted
);

    typedef enum logic [2:0] {
        S_BOOT,
        S_FETCH,
        S_WAIT,
        S_DRAIN,
        S_HALT
    } state_t;

    state_t           r_state;
    state_t           w_next_state;

    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_addr;
    logic [WIDTH-1:0] r_slot_instr;
    logic [WIDTH-1:0] r_slot_pc_plus2;
    logic             r_slot_valid;
    logic [WIDTH-1:0] r_skid_instr;
    logic [WIDTH-1:0] r_skid_pc_plus2;
    logic             r_skid_valid;

    logic             w_slot_open;
    logic             w_fetch_req;
    logic             w_req;
    logic [WIDTH-1:0] w_addr;
    logic [WIDTH-1:0] w_fetch_plus2;
    logic [WIDTH-1:0] w_redirect_target;
    logic             w_accept;
    logic             w_is_halt;

    // The slot can take a new word if it is empty or being consumed now.
    assign w_slot_open = !r_slot_valid || !i_stall;

    // A new request starts only from FETCH, with room downstream and no
    // redirect this cycle; WAIT and DRAIN keep the outstanding one alive.
    assign w_fetch_req = (r_state == S_FETCH) && w_slot_open && !r_skid_valid && !i_redirect;
    assign w_req       = w_fetch_req || (r_state == S_WAIT) || (r_state == S_DRAIN);

    // r_addr freezes the address of an outstanding request so DRAIN keeps
    // the old address even after a redirect has moved the PC.
    assign w_addr        = (r_state == S_FETCH) ? r_pc : r_addr;
    assign w_fetch_plus2 = w_addr + WIDTH'(2);

    assign w_redirect_target = i_redirect_pc & ~{{(WIDTH-1){1'b0}}, 1'b1};

    // A response is kept only for live requests; DRAIN and redirected
    // responses are dropped on the floor.
    assign w_accept  = imem.imem_ready && !i_redirect && (w_fetch_req || (r_state == S_WAIT));
    assign w_is_halt = (imem.imem_data[WIDTH-1 -: 4] == HALT_OPCODE);

    assign imem.imem_req  = w_req;
    assign imem.imem_addr = w_addr;

    assign o_pc          = r_pc;
    assign o_if_instr    = r_slot_instr;
    assign o_if_pc_plus2 = r_slot_pc_plus2;
    assign o_if_valid    = r_slot_valid;
    assign o_halted      = (r_state == S_HALT);

    // Next-state logic for the fetch sequencer.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_BOOT: begin
                w_next_state = S_FETCH;
            end
            S_FETCH: begin
                if (w_accept && w_is_halt) begin
                    w_next_state = S_HALT;
                end else if (w_fetch_req && !imem.imem_ready) begin
                    w_next_state = S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_redirect) begin
                    w_next_state = imem.imem_ready ? S_FETCH : S_DRAIN;
                end else if (imem.imem_ready) begin
                    w_next_state = w_is_halt ? S_HALT : S_FETCH;
                end
            end
            S_DRAIN: begin
                if (imem.imem_ready) begin
                    w_next_state = S_FETCH;
                end
            end
            S_HALT: begin
                if (i_redirect) begin
                    w_next_state = S_FETCH;
                end
            end
            default: begin
                w_next_state = S_BOOT;
            end
        endcase
    end

    // State, PC, held request address, output slot and skid entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= S_BOOT;
            r_pc            <= RESET_PC;
            r_addr          <= RESET_PC;
            r_slot_instr    <= '0;
            r_slot_pc_plus2 <= '0;
            r_slot_valid    <= 1'b0;
            r_skid_instr    <= '0;
            r_skid_pc_plus2 <= '0;
            r_skid_valid    <= 1'b0;
        end else begin
            r_state <= w_next_state;

            if (r_state == S_FETCH) begin
                r_addr <= r_pc;
            end

            // Redirect wins over everything; a HALT word leaves the PC
            // pointing at itself.
            if (i_redirect) begin
                r_pc <= w_redirect_target;
            end else if (w_accept && !w_is_halt) begin
                r_pc <= w_fetch_plus2;
            end

            if (i_redirect) begin
                r_slot_valid <= 1'b0;
                r_skid_valid <= 1'b0;
            end else if (w_accept) begin
                // A word arriving while decode holds a full slot parks in
                // the skid until decode releases the slot.
                if (w_slot_open) begin
                    r_slot_instr    <= imem.imem_data;
                    r_slot_pc_plus2 <= w_fetch_plus2;
                    r_slot_valid    <= 1'b1;
                end else begin
                    r_skid_instr    <= imem.imem_data;
                    r_skid_pc_plus2 <= w_fetch_plus2;
                    r_skid_valid    <= 1'b1;
                end
            end else if (!i_stall) begin
                if (r_skid_valid) begin
                    r_slot_instr    <= r_skid_instr;
                    r_slot_pc_plus2 <= r_skid_pc_plus2;
                    r_slot_valid    <= 1'b1;
                    r_skid_valid    <= 1'b0;
                end else begin
                    r_slot_valid <= 1'b0;
                end
            end
        end
    end

endmodule
